// File: rtl/data_mem_resp.sv
// Multi-cycle data-memory responder: valid/ready load/store request channel,
// one outstanding request, and a one-cycle response pulse after LATENCY edges.
module data_mem_resp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_be,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [3:0]              be_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [7:0]              mem_q [2**ADDR_WIDTH];

  logic                    accept;
  logic                    commit;
  logic                    mem_we;
  logic                    op_we;
  logic [ADDR_WIDTH-1:0]   op_addr;
  logic [DATA_WIDTH-1:0]   op_wdata;
  logic [3:0]              op_be;
  logic [ADDR_WIDTH-1:0]   op_base;
  logic                    op_misaligned;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign req_ready = (state_q != WAIT);
  assign busy      = (state_q == WAIT);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign accept    = req_valid & req_ready;

  // With LATENCY = 1 the acceptance edge is also the commit edge, so the
  // memory operation must use the live request rather than the captured one.
  assign op_we         = SINGLE ? req_we    : we_q;
  assign op_addr       = SINGLE ? req_addr  : addr_q;
  assign op_wdata      = SINGLE ? req_wdata : wdata_q;
  assign op_be         = SINGLE ? req_be    : be_q;
  assign op_base       = {op_addr[ADDR_WIDTH-1:2], 2'b00};
  assign op_misaligned = (op_addr[1:0] != 2'b00);
  assign mem_we        = commit & op_we & ~op_misaligned & rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          cnt_d = CNT_INIT;
          if (SINGLE) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      rd_word[8*i +: 8] = mem_q[op_base + ADDR_WIDTH'(i)];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = op_misaligned;
      rdata_d = (op_we || op_misaligned) ? '0 : rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  // Memory contents survive reset; writes are additionally gated by rst so a
  // reset edge can never commit a store.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) begin
          mem_q[op_base + ADDR_WIDTH'(i)] <= op_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: three instances at LATENCY 1, 2 and 4.
module tb_data_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       req_valid;
  logic [2:0]       req_we;
  logic [2:0][7:0]  req_addr;
  logic [2:0][31:0] req_wdata;
  logic [2:0][3:0]  req_be;
  wire  [2:0]       req_ready;
  wire  [2:0]       rsp_valid;
  wire  [2:0]       rsp_err;
  wire  [2:0]       busy;
  wire  [2:0][31:0] rsp_rdata;

  int checks   = 0;
  int failures = 0;

  data_mem_resp #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

  data_mem_resp #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

  data_mem_resp #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]), .busy(busy[2]));

  // Issue one request on instance k (called just after a negedge with req_ready
  // high) and return the response plus edges-after-acceptance and WAIT cycles.
  // Returns at the negedge inside the RESP cycle.
  task automatic xfer(input int k, input logic we, input logic [7:0] addr,
                      input logic [31:0] wd, input logic [3:0] be,
                      output logic [31:0] rd, output logic er,
                      output int lat, output int nbusy);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wd;
    req_be[k]    = be;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    while (!rsp_valid[k] && lat < 40) begin
      if (busy[k]) nbusy++;
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata[k];
    er = rsp_err[k];
  endtask

  task automatic test_reset();
    rst = '0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (req_ready[k] !== 1'b1) begin failures++; $display("FAIL reset_ready[%0d] got=%b exp=1", k, req_ready[k]); end
      checks++; if (busy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0", k, busy[k]); end
      checks++; if (rsp_valid[k] !== 1'b0) begin failures++; $display("FAIL reset_valid[%0d] got=%b exp=0", k, rsp_valid[k]); end
      checks++; if (rsp_rdata[k] !== 32'h0) begin failures++; $display("FAIL reset_rdata[%0d] got=%h exp=0", k, rsp_rdata[k]); end
      checks++; if (rsp_err[k] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d] got=%b exp=0", k, rsp_err[k]); end
    end
    rst = '1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (req_ready[k] !== 1'b1 || busy[k] !== 1'b0 || rsp_valid[k] !== 1'b0) begin
        failures++; $display("FAIL post_reset_idle[%0d] got ready=%b busy=%b valid=%b exp 1/0/0", k, req_ready[k], busy[k], rsp_valid[k]);
      end
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; int nb;
    xfer(1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, nb);
    checks++; if (lat !== 1) begin failures++; $display("FAIL st_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL st_rsp got rdata=%h err=%b exp 0/0", rd, er); end
    checks++; if (nb !== 1) begin failures++; $display("FAIL st_busy_cycles got=%0d exp=1", nb); end
    xfer(1, 1'b0, 8'h10, 32'h0, 4'h0, rd, er, lat, nb);
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL raw_load got=%h exp=deadbeef", rd); end
    checks++; if (lat !== 1 || nb !== 1) begin failures++; $display("FAIL ld_timing got lat=%0d busy=%0d exp 1/1", lat, nb); end
    @(negedge clk);
    checks++; if (rsp_valid[1] !== 1'b0 || busy[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
      failures++; $display("FAIL pulse_end got valid=%b busy=%b ready=%b exp 0/0/1", rsp_valid[1], busy[1], req_ready[1]);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat; int nb;
    xfer(1, 1'b1, 8'h20, 32'h11223344, 4'hF, rd, er, lat, nb);
    xfer(1, 1'b1, 8'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat, nb);
    xfer(1, 1'b0, 8'h20, 32'h0, 4'h0, rd, er, lat, nb);
    checks++; if (rd !== 32'h11BB33DD) begin failures++; $display("FAIL byte_enable got=%h exp=11bb33dd", rd); end
    xfer(1, 1'b1, 8'h24, 32'h99999999, 4'hF, rd, er, lat, nb);
    xfer(1, 1'b1, 8'h24, 32'h12345678, 4'h0, rd, er, lat, nb);
    checks++; if (lat !== 1 || er !== 1'b0) begin failures++; $display("FAIL be_zero_rsp got lat=%0d err=%b exp 1/0", lat, er); end
    xfer(1, 1'b0, 8'h24, 32'h0, 4'h0, rd, er, lat, nb);
    checks++; if (rd !== 32'h99999999) begin failures++; $display("FAIL be_zero_mem got=%h exp=99999999", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat; int nb;
    xfer(1, 1'b0, 8'h13, 32'h0, 4'h0, rd, er, lat, nb);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL mis_load got err=%b rdata=%h exp 1/0", er, rd); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL mis_load_lat got=%0d exp=1", lat); end
    xfer(1, 1'b1, 8'h22, 32'hFFFFFFFF, 4'hF, rd, er, lat, nb);
    checks++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 1) begin failures++; $display("FAIL mis_store got err=%b rdata=%h lat=%0d exp 1/0/1", er, rd, lat); end
    xfer(1, 1'b0, 8'h20, 32'h0, 4'h0, rd, er, lat, nb);
    checks++; if (rd !== 32'h11BB33DD || er !== 1'b0) begin failures++; $display("FAIL mis_unchanged got=%h err=%b exp 11bb33dd/0", rd, er); end
  endtask

  task automatic test_committed_reset();
    logic [31:0] rd; logic er; int lat; int nb;
    xfer(1, 1'b1, 8'h40, 32'h0F0F0F0F, 4'hF, rd, er, lat, nb);
    rst[1] = 1'b0;
    @(negedge clk);
    rst[1] = 1'b1;
    xfer(1, 1'b0, 8'h40, 32'h0, 4'h0, rd, er, lat, nb);
    checks++; if (rd !== 32'h0F0F0F0F) begin failures++; $display("FAIL committed_kept got=%h exp=0f0f0f0f", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] tbl [4];
    logic [31:0] rd; logic er; int lat; int nb;
    tbl[0] = 32'h01020304; tbl[1] = 32'hA5A55A5A; tbl[2] = 32'hFFFF0000; tbl[3] = 32'h87654321;
    for (int i = 0; i < 4; i++) begin
      xfer(0, 1'b1, 8'(4*i), tbl[i], 4'hF, rd, er, lat, nb);
      checks++; if (lat !== 0 || nb !== 0) begin failures++; $display("FAIL l1_store_lat[%0d] got lat=%0d busy=%0d exp 0/0", i, lat, nb); end
    end
    for (int i = 0; i < 4; i++) begin
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'(4*i); req_be[0] = 4'h0;
      @(negedge clk);
      checks++; if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b1) begin
        failures++; $display("FAIL l1_pulse[%0d] got valid=%b ready=%b exp 1/1", i, rsp_valid[0], req_ready[0]);
      end
      checks++; if (rsp_rdata[0] !== tbl[i]) begin failures++; $display("FAIL l1_data[%0d] got=%h exp=%h", i, rsp_rdata[0], tbl[i]); end
    end
    req_valid[0] = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL l1_drain got valid=%b exp=0", rsp_valid[0]); end
  endtask

  task automatic test_wait_ignored();
    logic [31:0] rd; logic er; int lat; int nb;
    xfer(2, 1'b1, 8'h30, 32'h55AA55AA, 4'hF, rd, er, lat, nb);
    checks++; if (lat !== 3 || nb !== 3) begin failures++; $display("FAIL l4_latency got lat=%0d busy=%0d exp 3/3", lat, nb); end
    xfer(2, 1'b1, 8'h38, 32'hCAFEF00D, 4'hF, rd, er, lat, nb);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_addr[2] = 8'h30; req_be[2] = 4'h0;
    @(posedge clk);
    #1 req_we[2] = 1'b1; req_addr[2] = 8'h38; req_wdata[2] = 32'h0BADBEEF; req_be[2] = 4'hF;
    lat = 0;
    @(negedge clk);
    checks++; if (req_ready[2] !== 1'b0 || busy[2] !== 1'b1) begin failures++; $display("FAIL wait_ready got ready=%b busy=%b exp 0/1", req_ready[2], busy[2]); end
    while (!rsp_valid[2] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    req_valid[2] = 1'b0;
    checks++; if (lat !== 3 || rsp_rdata[2] !== 32'h55AA55AA) begin
      failures++; $display("FAIL wait_load got lat=%0d rdata=%h exp 3/55aa55aa", lat, rsp_rdata[2]);
    end
    @(negedge clk);
    checks++; if (rsp_valid[2] !== 1'b0 || busy[2] !== 1'b0) begin failures++; $display("FAIL wait_idle got valid=%b busy=%b exp 0/0", rsp_valid[2], busy[2]); end
    xfer(2, 1'b0, 8'h38, 32'h0, 4'h0, rd, er, lat, nb);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL wait_not_accepted got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat; int nb; int pulses;
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 8'h30; req_wdata[2] = 32'h12345678; req_be[2] = 4'hF;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst[2] = 1'b0;
    #1;
    checks++; if (busy[2] !== 1'b0 || req_ready[2] !== 1'b1 || rsp_valid[2] !== 1'b0) begin
      failures++; $display("FAIL mid_reset_state got busy=%b ready=%b valid=%b exp 0/1/0", busy[2], req_ready[2], rsp_valid[2]);
    end
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) pulses++;
    end
    rst[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid[2]) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL mid_reset_pulses got=%0d exp=0", pulses); end
    xfer(2, 1'b0, 8'h30, 32'h0, 4'h0, rd, er, lat, nb);
    checks++; if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL mid_reset_mem got=%h exp=55aa55aa", rd); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_misaligned();
    test_committed_reset();
    test_back_to_back();
    test_wait_ignored();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
